vscale_hazard_ctrl: RTL
=======================

// Module: vscale_hazard_ctrl
// PURPOSE
//  Parametrised hazard/forwarding controller for deeper vscale pipelines. Tracks NUM_STAGES in-order
//  stages after DX, picks a one-hot forward source per DX operand, and stalls DX on load-use,
//  full or busy long-latency (mul/div) units, and scoreboarded RAW/WAW hazards. Sits beside the
//  core control decoder, which supplies decoded DX fields and consumes stall/kill/forward selects.
// PARAMETERS
//  NUM_STAGES       2  stages tracked after DX (last stage = WB/commit); legal range 1..6
//  LOAD_DATA_STAGE  2  first stage (1-based) whose load data can be forwarded; 1..NUM_STAGES
//  REG_ADDR_WIDTH   5  architectural register address width; scoreboard is 2**REG_ADDR_WIDTH bits
//  MAX_OUTSTANDING  2  maximum long-latency ops in flight; 1..15
// PORTS
//  clk           in   1   clock
//  reset         in   1   synchronous, active-high reset
//  dx_valid      in   1   DX holds a live instruction
//  dx_rs1/dx_rs2 in   RAW source addresses (REG_ADDR_WIDTH each)
//  dx_uses_rs1/2 in   1   operand is read
//  dx_rd         in   REG_ADDR_WIDTH  destination
//  dx_wr_reg     in   1   instruction writes rd
//  dx_is_load    in   1   load (result available from LOAD_DATA_STAGE)
//  dx_is_long    in   1   long-latency op; result returns via long_resp_*
//  long_req_ready in  1   long unit accepts a request this cycle
//  long_resp_valid in 1   long result written back this cycle
//  long_resp_rd  in   REG_ADDR_WIDTH  destination of returning result
//  stall_back    in   1   downstream stall (dmem wait etc.); freezes all tracked stages
//  flush         in   1   exception/interrupt/redirect: kill DX and stages 1..NUM_STAGES-1
//  stall_DX      out  1   DX must hold
//  kill_DX       out  1   DX instruction becomes a bubble
//  long_req_valid out 1   issue long op (dx_valid&dx_is_long&!stall_DX&!kill_DX)
//  fwd_rs1_sel/fwd_rs2_sel out NUM_STAGES  one-hot forward source (bit i = stage i+1); 0 = regfile
//  outstanding   out  4   long ops in flight
//  sb_error      out  1   sticky: response with outstanding==0 or rd bit not set
// BEHAVIOUR
//  - Reset: stage valids, scoreboard, outstanding, sb_error <= 0; all outputs 0 with dx_valid=0.
//  - Match(i,rs): stage i valid & wr_reg & rd==rs & rs!=0 & uses_rs. Youngest (lowest i) wins.
//  - Winner is a load with i<LOAD_DATA_STAGE -> load_use stall; otherwise fwd_sel=onehot(i).
//  - Long ops enter the pipe with wr_reg cleared; their rd is tracked only by the scoreboard.
//  - Scoreboard stall when sb[rs] is set for a used rs (RAW), or sb[dx_rd] is set with dx_wr_reg (WAW).
//  - Long stall when dx_is_long and (!long_req_ready or outstanding==MAX_OUTSTANDING).
//  - stall_DX = stall_back | ((load_use|sb_stall|long_stall) & dx_valid & !flush).
//  - kill_DX = stall_DX | flush.
//  - Advance when !stall_back: stage1 <= DX entry if dx_valid&!kill_DX, else a bubble;
//    stage i+1 <= stage i. With stall_back, all stages hold.
//  - flush (takes priority over stall_back for clearing): stages 1..NUM_STAGES-1 valid<=0 next
//    cycle; the last stage is not killed.
//  - Issue sets sb[dx_rd] (when rd!=0) and increments outstanding. Response clears sb[long_resp_rd]
//    and decrements it. Issue and response in the same cycle leave outstanding unchanged. The same
//    rd cannot be issued and cleared in one cycle (WAW stall). The scoreboard is not cleared by flush.
//  - A response seen with outstanding==0 leaves the count at 0 and sets sb_error (cleared only by reset).
//  - Reset asserted mid-operation discards in-flight state; late responses then set sb_error.
//  - Latency: all stalls, kills and selects are combinational from the current state and DX inputs;
//    the scoreboard is updated one cycle after issue or response.
// CONFIGURATION
//  HAZARD_PERF_CNT_EN defined:
//    - Adds outputs perf_load_use, perf_sb_stall, perf_long_stall (32 bits each).
//    - Each counter increments once per cycle its cause contributes to stall_DX. Multiple causes in
//      one cycle each count. Counters wrap at 2**32 and reset to 0.
//  Not defined: the ports are still present, tied to 0; no counter flops are built.
// TESTING
//  1 reset high 2 cycles, dx_valid=0 -> stall_DX=0, kill_DX=0, fwd_sel=0, outstanding=0, sb_error=0
//  2 NUM_STAGES=2: add x5 issued; next cycle DX rs1=x5 -> fwd_rs1_sel=2'b01, stall_DX=0;
//    next-next cycle -> 2'b10
//  3 lw x6 issued, next DX rs2=x6 (LOAD_DATA_STAGE=2) -> stall_DX=1 for 1 cycle,
//    then fwd_rs2_sel=2'b10
//  4 mul x7 issued, DX rs1=x7 -> stall until long_resp_valid rd=7; stall_DX=0 on the following cycle
//  5 MAX_OUTSTANDING=2: two long ops to x8,x9; a third to x10 stalls -> after x8 resp, x10 issues,
//    outstanding stays 2
//  6 flush with stage1,stage2 valid -> next cycle stage1 invalid, stage2 content retired;
//    long_resp with outstanding=0 -> sb_error=1

Source files
------------

// File: rtl/vscale_hazard_ctrl.sv
// rtl/vscale_hazard_ctrl.sv - forwarding select, load-use/scoreboard/long-unit stall control for deep vscale pipes
// Optional feature macro: HAZARD_PERF_CNT_EN builds the stall-cause performance counters.
module vscale_hazard_ctrl #(
  parameter int NUM_STAGES      = 2,
  parameter int LOAD_DATA_STAGE = 2,
  parameter int REG_ADDR_WIDTH  = 5,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      dx_valid,
  input  logic [REG_ADDR_WIDTH-1:0] dx_rs1,
  input  logic [REG_ADDR_WIDTH-1:0] dx_rs2,
  input  logic                      dx_uses_rs1,
  input  logic                      dx_uses_rs2,
  input  logic [REG_ADDR_WIDTH-1:0] dx_rd,
  input  logic                      dx_wr_reg,
  input  logic                      dx_is_load,
  input  logic                      dx_is_long,
  input  logic                      long_req_ready,
  input  logic                      long_resp_valid,
  input  logic [REG_ADDR_WIDTH-1:0] long_resp_rd,
  input  logic                      stall_back,
  input  logic                      flush,
  output logic                      stall_DX,
  output logic                      kill_DX,
  output logic                      long_req_valid,
  output logic [NUM_STAGES-1:0]     fwd_rs1_sel,
  output logic [NUM_STAGES-1:0]     fwd_rs2_sel,
  output logic [3:0]                outstanding,
  output logic                      sb_error,
  output logic [31:0]               perf_load_use,
  output logic [31:0]               perf_sb_stall,
  output logic [31:0]               perf_long_stall
);

  localparam int NUM_REGS = 1 << REG_ADDR_WIDTH;

  logic [NUM_STAGES-1:0]     v_q, v_d, wr_q, wr_d, ld_q, ld_d;
  logic [REG_ADDR_WIDTH-1:0] rd_q [NUM_STAGES];
  logic [REG_ADDR_WIDTH-1:0] rd_d [NUM_STAGES];
  logic [NUM_REGS-1:0]       sb_q, sb_d;
  logic [3:0]                out_q, out_d;
  logic                      err_q, err_d;

  logic [NUM_STAGES-1:0] sel1, sel2;
  logic                  lu1, lu2;
  logic                  load_use, sb_stall, long_stall;
  logic                  lu_cause, sb_cause, long_cause;

  // Scan oldest to youngest so the youngest matching stage overwrites the select.
  always_comb begin
    sel1 = '0;
    sel2 = '0;
    lu1  = 1'b0;
    lu2  = 1'b0;
    for (int i = NUM_STAGES - 1; i >= 0; i--) begin
      if (v_q[i] && wr_q[i] && dx_uses_rs1 && (dx_rs1 != '0) && (rd_q[i] == dx_rs1)) begin
        sel1    = '0;
        sel1[i] = 1'b1;
        lu1     = ld_q[i] && ((i + 1) < LOAD_DATA_STAGE);
      end
      if (v_q[i] && wr_q[i] && dx_uses_rs2 && (dx_rs2 != '0) && (rd_q[i] == dx_rs2)) begin
        sel2    = '0;
        sel2[i] = 1'b1;
        lu2     = ld_q[i] && ((i + 1) < LOAD_DATA_STAGE);
      end
    end
  end

  assign fwd_rs1_sel = lu1 ? '0 : sel1;
  assign fwd_rs2_sel = lu2 ? '0 : sel2;
  assign load_use    = lu1 | lu2;

  assign sb_stall   = (dx_uses_rs1 & sb_q[dx_rs1]) | (dx_uses_rs2 & sb_q[dx_rs2]) |
                      (dx_wr_reg & sb_q[dx_rd]);
  assign long_stall = dx_is_long & (~long_req_ready | (out_q == 4'(MAX_OUTSTANDING)));

  assign lu_cause   = load_use   & dx_valid & ~flush;
  assign sb_cause   = sb_stall   & dx_valid & ~flush;
  assign long_cause = long_stall & dx_valid & ~flush;

  assign stall_DX       = stall_back | lu_cause | sb_cause | long_cause;
  assign kill_DX        = stall_DX | flush;
  assign long_req_valid = dx_valid & dx_is_long & ~kill_DX;
  assign outstanding    = out_q;
  assign sb_error       = err_q;

  // Long ops enter the pipe with wr cleared; only the scoreboard tracks their rd.
  always_comb begin
    v_d  = v_q;
    wr_d = wr_q;
    ld_d = ld_q;
    rd_d = rd_q;
    if (!stall_back) begin
      v_d[0]  = dx_valid & ~kill_DX;
      wr_d[0] = dx_wr_reg & ~dx_is_long;
      ld_d[0] = dx_is_load;
      rd_d[0] = dx_rd;
      for (int i = 1; i < NUM_STAGES; i++) begin
        v_d[i]  = v_q[i-1];
        wr_d[i] = wr_q[i-1];
        ld_d[i] = ld_q[i-1];
        rd_d[i] = rd_q[i-1];
      end
    end
    if (flush) begin
      for (int i = 0; i < NUM_STAGES - 1; i++) v_d[i] = 1'b0;
    end
  end

  always_comb begin
    sb_d  = sb_q;
    out_d = out_q;
    if (long_resp_valid) sb_d[long_resp_rd] = 1'b0;
    if (long_req_valid && (dx_rd != '0)) sb_d[dx_rd] = 1'b1;
    case ({long_req_valid, long_resp_valid && (out_q != 4'd0)})
      2'b10:   out_d = out_q + 4'd1;
      2'b01:   out_d = out_q - 4'd1;
      default: out_d = out_q;
    endcase
    err_d = err_q | (long_resp_valid &
            ((out_q == 4'd0) | ((long_resp_rd != '0) & ~sb_q[long_resp_rd])));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v_q   <= '0;
      wr_q  <= '0;
      ld_q  <= '0;
      sb_q  <= '0;
      out_q <= 4'd0;
      err_q <= 1'b0;
      for (int i = 0; i < NUM_STAGES; i++) rd_q[i] <= '0;
    end else begin
      v_q   <= v_d;
      wr_q  <= wr_d;
      ld_q  <= ld_d;
      rd_q  <= rd_d;
      sb_q  <= sb_d;
      out_q <= out_d;
      err_q <= err_d;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] perf_lu_q, perf_sb_q, perf_long_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_lu_q   <= 32'd0;
      perf_sb_q   <= 32'd0;
      perf_long_q <= 32'd0;
    end else begin
      if (lu_cause)   perf_lu_q   <= perf_lu_q + 32'd1;
      if (sb_cause)   perf_sb_q   <= perf_sb_q + 32'd1;
      if (long_cause) perf_long_q <= perf_long_q + 32'd1;
    end
  end

  assign perf_load_use   = perf_lu_q;
  assign perf_sb_stall   = perf_sb_q;
  assign perf_long_stall = perf_long_q;
`else
  assign perf_load_use   = 32'd0;
  assign perf_sb_stall   = 32'd0;
  assign perf_long_stall = 32'd0;
`endif

endmodule
